// File: rtl/cam_read_register_table.sv
// Reads back a camera register group over the I2C engine, one sensor register at a time,
// and packs the returned 16-bit values into the 64-bit reg_data layout used by the write path.
module cam_read_register_table #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
   input  logic        sysClk,
   input  logic        sysRst_n,
   input  logic [7:0]  reg_addr,
   input  logic        rd_req,
   output logic        i2c_req,
   output logic [7:0]  i2c_reg_addr,
   output logic        i2c_cam_id,
   input  logic        i2c_req_ready,
   input  logic [7:0]  i2c_rx_byte,
   input  logic        i2c_rx_valid,
   input  logic        i2c_err,
   output logic [63:0] rd_data,
   output logic        rd_valid,
   output logic        rd_error,
   output logic        rd_cam_id,
   output logic        busy
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_WAIT_HI = 3'd2,
      ST_WAIT_LO = 3'd3,
      ST_NEXT    = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   state_t      state_r, state_s;
   logic        grp_exp_r;
   logic [2:0]  idx_r;
   logic [7:0]  hi_r;
   logic [15:0] cnt_r;
   logic        i2c_req_r, i2c_cam_id_r, rd_valid_r, rd_error_r, rd_cam_id_r, busy_r;
   logic [7:0]  i2c_reg_addr_r;
   logic [63:0] rd_data_r;

   logic        req_exp_s, req_crop_s, addr_ok_s, req_cam_s, accept_s;
   logic        last_s, in_wait_s, timeout_s, fail_s, issue_entry_s, issue_grp_s;
   logic [2:0]  issue_idx_s;

   // Sensor register address for a given group and sequence position.
   function automatic logic [7:0] sensor_addr_f(input logic exp_grp, input logic [2:0] idx);
      logic [7:0] a;
      a = 8'h00;
      if (exp_grp) begin
         case (idx)
            3'd0:    a = 8'h08;
            3'd1:    a = 8'h09;
            3'd2:    a = 8'h0C;
            3'd3:    a = 8'h22;
            3'd4:    a = 8'h23;
            3'd5:    a = 8'h05;
            3'd6:    a = 8'h06;
            default: a = 8'h00;
         endcase
      end else begin
         case (idx)
            3'd0:    a = 8'h01;
            3'd1:    a = 8'h02;
            3'd2:    a = 8'h03;
            3'd3:    a = 8'h04;
            default: a = 8'h00;
         endcase
      end
      return a;
   endfunction

   // Merges one returned register value into its reg_data fields; other bits are kept.
   function automatic logic [63:0] pack_f(input logic [63:0] d, input logic exp_grp,
                                          input logic [2:0] idx, input logic [7:0] hi,
                                          input logic [7:0] lo);
      logic [63:0] r;
      r = d;
      if (exp_grp) begin
         case (idx)
            3'd0: r[22:19] = lo[3:0];
            3'd1: begin r[18:11] = hi;      r[10:3]  = lo; end
            3'd2: begin r[35:31] = hi[4:0]; r[30:23] = lo; end
            3'd3: r[37:36] = lo[5:4];
            3'd4: r[39:38] = lo[5:4];
            3'd5: begin r[51:48] = hi[3:0]; r[47:40] = lo; end
            3'd6: begin r[62:60] = hi[2:0]; r[59:52] = lo; end
            default: r = d;
         endcase
      end else begin
         case (idx)
            3'd0: begin r[10:8]  = hi[2:0]; r[7:0]   = lo; end
            3'd1: begin r[22:19] = hi[3:0]; r[18:11] = lo; end
            3'd2: begin r[33:31] = hi[2:0]; r[30:23] = lo; end
            3'd3: begin r[45:42] = hi[3:0]; r[41:34] = lo; end
            default: r = d;
         endcase
      end
      return r;
   endfunction

   assign req_exp_s     = (reg_addr == 8'h02) || (reg_addr == 8'h03);
   assign req_crop_s    = (reg_addr == 8'h05) || (reg_addr == 8'h06);
   assign addr_ok_s     = req_exp_s || req_crop_s;
   assign req_cam_s     = (reg_addr == 8'h03) || (reg_addr == 8'h06);
   assign accept_s      = (state_r == ST_IDLE) && rd_req;
   assign last_s        = grp_exp_r ? (idx_r == 3'd6) : (idx_r == 3'd3);
   assign in_wait_s     = (state_r == ST_ISSUE) || (state_r == ST_WAIT_HI) || (state_r == ST_WAIT_LO);
   assign timeout_s     = in_wait_s && (cnt_r >= (TIMEOUT_CYCLES - 16'd1));
   assign issue_entry_s = (state_s == ST_ISSUE) && (state_r != ST_ISSUE);
   assign issue_grp_s   = accept_s ? req_exp_s : grp_exp_r;
   assign issue_idx_s   = accept_s ? 3'd0 : (idx_r + 3'd1);

   // Next-state logic; an engine error or timeout beats any byte arriving in the same cycle.
   always_comb begin
      state_s = state_r;
      fail_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (rd_req) begin
               state_s = addr_ok_s ? ST_ISSUE : ST_DONE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (i2c_err || timeout_s) begin
               fail_s  = 1'b1;
               state_s = ST_DONE;
            end else if (i2c_req_r && i2c_req_ready) begin
               state_s = ST_WAIT_HI;
            end else begin
               state_s = ST_ISSUE;
            end
         end
         ST_WAIT_HI: begin
            if (i2c_err || timeout_s) begin
               fail_s  = 1'b1;
               state_s = ST_DONE;
            end else if (i2c_rx_valid) begin
               state_s = ST_WAIT_LO;
            end else begin
               state_s = ST_WAIT_HI;
            end
         end
         ST_WAIT_LO: begin
            if (i2c_err || timeout_s) begin
               fail_s  = 1'b1;
               state_s = ST_DONE;
            end else if (i2c_rx_valid) begin
               state_s = ST_NEXT;
            end else begin
               state_s = ST_WAIT_LO;
            end
         end
         ST_NEXT: begin
            if (last_s) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_ISSUE;
            end
         end
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge sysClk or negedge sysRst_n) begin
      if (!sysRst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Wait-state watchdog: restarts on every state change, which covers each accepted byte.
   always_ff @(posedge sysClk or negedge sysRst_n) begin
      if (!sysRst_n) begin
         cnt_r <= 16'd0;
      end else if ((state_s != state_r) || !in_wait_s) begin
         cnt_r <= 16'd0;
      end else begin
         cnt_r <= cnt_r + 16'd1;
      end
   end

   // Request, sequencing and result registers.
   always_ff @(posedge sysClk or negedge sysRst_n) begin
      if (!sysRst_n) begin
         grp_exp_r      <= 1'b0;
         idx_r          <= 3'd0;
         hi_r           <= 8'h00;
         i2c_req_r      <= 1'b0;
         i2c_reg_addr_r <= 8'h00;
         i2c_cam_id_r   <= 1'b0;
         rd_data_r      <= 64'h0;
         rd_valid_r     <= 1'b0;
         rd_error_r     <= 1'b0;
         rd_cam_id_r    <= 1'b0;
         busy_r         <= 1'b0;
      end else begin
         i2c_req_r  <= (state_s == ST_ISSUE);
         rd_valid_r <= (state_r == ST_DONE);
         // busy stays up through the rd_valid cycle that follows DONE
         busy_r     <= (state_s != ST_IDLE) || (state_r == ST_DONE);
         if (issue_entry_s) begin
            i2c_reg_addr_r <= sensor_addr_f(issue_grp_s, issue_idx_s);
         end
         if (accept_s) begin
            grp_exp_r    <= req_exp_s;
            idx_r        <= 3'd0;
            i2c_cam_id_r <= req_cam_s;
            rd_cam_id_r  <= req_cam_s;
            rd_data_r    <= 64'h0;
            rd_error_r   <= !addr_ok_s;
         end else if (fail_s) begin
            rd_data_r  <= 64'h0;
            rd_error_r <= 1'b1;
         end else begin
            case (state_r)
               ST_WAIT_HI: if (i2c_rx_valid) hi_r <= i2c_rx_byte;
               ST_WAIT_LO: if (i2c_rx_valid) rd_data_r <= pack_f(rd_data_r, grp_exp_r, idx_r, hi_r, i2c_rx_byte);
               ST_NEXT:    if (!last_s) idx_r <= idx_r + 3'd1;
               default:    hi_r <= hi_r;
            endcase
         end
      end
   end

   assign i2c_req      = i2c_req_r;
   assign i2c_reg_addr = i2c_reg_addr_r;
   assign i2c_cam_id   = i2c_cam_id_r;
   assign rd_data      = rd_data_r;
   assign rd_valid     = rd_valid_r;
   assign rd_error     = rd_error_r;
   assign rd_cam_id    = rd_cam_id_r;
   assign busy         = busy_r;

endmodule

// File: tb/tb_cam_read_register_table.sv
// Directed bench for cam_read_register_table: a cycle-by-cycle I2C engine model answers each
// request with a hand-chosen {hi,lo} value and results are compared with hand-packed constants.
module tb_cam_read_register_table;

   logic        sysClk = 1'b0;
   logic        sysRst_n;
   logic [7:0]  reg_addr;
   logic        rd_req;
   logic        i2c_req;
   logic [7:0]  i2c_reg_addr;
   logic        i2c_cam_id;
   logic        i2c_req_ready;
   logic [7:0]  i2c_rx_byte;
   logic        i2c_rx_valid;
   logic        i2c_err;
   logic [63:0] rd_data;
   logic        rd_valid;
   logic        rd_error;
   logic        rd_cam_id;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   logic [15:0] resp [0:7];
   logic [7:0]  seen [0:15];
   logic [7:0]  exp_a [0:6];
   int          n_seen, v_cyc;
   logic        got_v, got_err, got_cam, cam_seen, busy_at1, busy_at_v, busy_after, req_at_v;
   logic [63:0] got_data;

   cam_read_register_table #(.TIMEOUT_CYCLES(16'd20)) dut (
      .sysClk(sysClk), .sysRst_n(sysRst_n), .reg_addr(reg_addr), .rd_req(rd_req),
      .i2c_req(i2c_req), .i2c_reg_addr(i2c_reg_addr), .i2c_cam_id(i2c_cam_id),
      .i2c_req_ready(i2c_req_ready), .i2c_rx_byte(i2c_rx_byte), .i2c_rx_valid(i2c_rx_valid),
      .i2c_err(i2c_err), .rd_data(rd_data), .rd_valid(rd_valid), .rd_error(rd_error),
      .rd_cam_id(rd_cam_id), .busy(busy)
   );

   always #5 sysClk = ~sysClk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issues one request (inputs driven 1 time unit after a rising edge = cycle 0) and plays the
   // engine: hi byte the cycle after a transfer, lo byte the cycle after that. err_reg selects the
   // register whose lo-byte cycle also carries i2c_err (-1 for none).
   task automatic run_read(input logic [7:0] addr, input int err_reg);
      int phase;
      int ridx;
      phase = 0; ridx = 0; n_seen = 0; got_v = 1'b0; v_cyc = -1; busy_at1 = 1'b0;
      reg_addr = addr;
      rd_req   = 1'b1;
      for (int c = 1; c <= 100 && !got_v; c++) begin
         @(posedge sysClk); #1;
         rd_req = 1'b0; i2c_rx_valid = 1'b0; i2c_err = 1'b0;
         if (c == 1) busy_at1 = busy;
         if (rd_valid) begin
            got_v = 1'b1; v_cyc = c; got_data = rd_data; got_err = rd_error;
            got_cam = rd_cam_id; busy_at_v = busy; req_at_v = i2c_req;
         end else begin
            if (phase == 1) begin
               i2c_rx_valid = 1'b1; i2c_rx_byte = resp[ridx][15:8]; phase = 2;
            end else if (phase == 2) begin
               i2c_rx_valid = 1'b1; i2c_rx_byte = resp[ridx][7:0];
               if (ridx == err_reg) i2c_err = 1'b1;
               phase = 0; ridx++;
            end
            if (i2c_req && i2c_req_ready) begin
               if (n_seen < 16) seen[n_seen] = i2c_reg_addr;
               n_seen++;
               cam_seen = i2c_cam_id;
               phase = 1;
            end
         end
      end
      chk("rd_valid_seen", {63'd0, got_v}, 64'd1);
      @(posedge sysClk); #1;
      busy_after = busy;
   endtask

   initial begin
      sysRst_n = 1'b0; reg_addr = 8'h00; rd_req = 1'b0; i2c_req_ready = 1'b1;
      i2c_rx_byte = 8'h00; i2c_rx_valid = 1'b0; i2c_err = 1'b0;
      #12;
      chk("reset_outputs", {i2c_req, i2c_reg_addr, i2c_cam_id, rd_valid, rd_error, rd_cam_id, busy}, 64'd0);
      chk("reset_rd_data", rd_data, 64'd0);
      @(posedge sysClk); #1;
      sysRst_n = 1'b1;
      @(posedge sysClk); #1;

      // Exposure group, camera 1.
      resp = '{16'h000A, 16'h1234, 16'h0005, 16'h0030, 16'h0010, 16'h005E, 16'h0019, 16'h0000};
      exp_a = '{8'h08, 8'h09, 8'h0C, 8'h22, 8'h23, 8'h05, 8'h06};
      run_read(8'h03, -1);
      chk("exp_n_req", 64'(n_seen), 64'd7);
      for (int i = 0; i < 7; i++) chk($sformatf("exp_addr%0d", i), {56'd0, seen[i]}, {56'd0, exp_a[i]});
      chk("exp_i2c_cam", {63'd0, cam_seen}, 64'd1);
      chk("exp_data", got_data, 64'h0190_5E70_02D0_91A0);
      chk("exp_valid_cycle", 64'(v_cyc), 64'd30);
      chk("exp_error", {63'd0, got_err}, 64'd0);
      chk("exp_rd_cam", {63'd0, got_cam}, 64'd1);
      chk("exp_busy_c1", {63'd0, busy_at1}, 64'd1);
      chk("exp_busy_valid", {63'd0, busy_at_v}, 64'd1);
      chk("exp_busy_after", {63'd0, busy_after}, 64'd0);
      chk("exp_data_held", rd_data, 64'h0190_5E70_02D0_91A0);

      // Crop group, camera 0.
      resp = '{16'h0014, 16'h0020, 16'h03C0, 16'h0500, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      exp_a = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00};
      run_read(8'h05, -1);
      chk("crop_n_req", 64'(n_seen), 64'd4);
      for (int i = 0; i < 4; i++) chk($sformatf("crop_addr%0d", i), {56'd0, seen[i]}, {56'd0, exp_a[i]});
      chk("crop_i2c_cam", {63'd0, cam_seen}, 64'd0);
      chk("crop_data", got_data, 64'h0000_1401_E001_0014);
      chk("crop_valid_cycle", 64'(v_cyc), 64'd18);
      chk("crop_error", {63'd0, got_err}, 64'd0);

      // Unmapped table address.
      run_read(8'h07, -1);
      chk("inv_n_req", 64'(n_seen), 64'd0);
      chk("inv_valid_cycle", 64'(v_cyc), 64'd2);
      chk("inv_error", {63'd0, got_err}, 64'd1);
      chk("inv_data", got_data, 64'd0);

      // Engine error together with the lo byte of the third crop register.
      run_read(8'h05, 2);
      chk("err_n_req", 64'(n_seen), 64'd3);
      chk("err_valid_cycle", 64'(v_cyc), 64'd13);
      chk("err_error", {63'd0, got_err}, 64'd1);
      chk("err_data", got_data, 64'd0);
      run_read(8'h05, -1);
      chk("err_next_data", got_data, 64'h0000_1401_E001_0014);
      chk("err_next_error", {63'd0, got_err}, 64'd0);

      // Engine never ready: ISSUE lasts 20 cycles (1..20), DONE at 21, rd_valid at 22.
      i2c_req_ready = 1'b0;
      run_read(8'h02, -1);
      i2c_req_ready = 1'b1;
      chk("to_valid_cycle", 64'(v_cyc), 64'd22);
      chk("to_error", {63'd0, got_err}, 64'd1);
      chk("to_req_dropped", {63'd0, req_at_v}, 64'd0);
      chk("to_data", got_data, 64'd0);

      // Reset while waiting for the hi byte of the first exposure register.
      reg_addr = 8'h03; rd_req = 1'b1;
      @(posedge sysClk); #1;
      rd_req = 1'b0;
      @(posedge sysClk); #1;
      sysRst_n = 1'b0;
      #1;
      chk("rst_mid_outputs", {i2c_req, i2c_reg_addr, i2c_cam_id, rd_valid, rd_error, rd_cam_id, busy}, 64'd0);
      chk("rst_mid_data", rd_data, 64'd0);
      @(posedge sysClk); #1;
      sysRst_n = 1'b1;
      @(posedge sysClk); #1;
      chk("rst_no_valid", {62'd0, rd_valid, busy}, 64'd0);
      resp = '{16'h0014, 16'h0020, 16'h03C0, 16'h0500, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      run_read(8'h06, -1);
      chk("post_rst_data", got_data, 64'h0000_1401_E001_0014);
      chk("post_rst_cycle", 64'(v_cyc), 64'd18);
      chk("post_rst_cam", {62'd0, cam_seen, got_cam}, 64'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
